// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Tags carry a requester id sized for the largest supported requester count.
package mult_sched_pkg;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefLatency = 5;
    localparam int unsigned MaxReq     = 8;
    localparam int unsigned IdW        = 3;

    typedef struct packed {
        logic           valid;
        logic [IdW-1:0] id;
    } tag_t;

    // First set bit of req at or after ptr, wrapping modulo n; one-hot or zero.
    function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                  input logic [IdW-1:0]    ptr,
                                                  input int unsigned       n);
        logic [MaxReq-1:0] gnt;
        logic              found;
        int unsigned       idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            idx = (32'(ptr) + i) % n;
            if ((i < n) && !found && req[idx[IdW-1:0]]) begin
                gnt[idx[IdW-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mult_rr_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus the rotating priority pointer.
// The pointer moves just past the winner whenever a grant is made.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int unsigned  NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              gnt_any_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_o = NumReq'(rr_pick(MaxReq'(req_i), IdW'(ptr_q), NumReq));
    end

    always_comb begin
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (gnt_o[i]) begin
                gnt_idx_o = IdxW'(i);
            end
        end
        gnt_any_o = |gnt_o;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any_o) begin
            if (gnt_idx_o == IdxW'(NumReq - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_o + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among requesters.
// Define MULT_RR_SCHED_STATS_EN to add grant/busy counters and their clear input.
module mult_rr_sched
    import mult_sched_pkg::*;
#(
    parameter int unsigned  NumReq  = 4,
    parameter int unsigned  DataW   = DefDataW,
    parameter int unsigned  Latency = DefLatency,
    localparam int unsigned IdxW    = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sched_en_i,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq*DataW-1:0] req_a_i,
    input  logic [NumReq*DataW-1:0] req_b_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic [DataW-1:0]        mul_a_o,
    output logic [DataW-1:0]        mul_b_o,
    input  logic [2*DataW-1:0]      mul_product_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    output logic [IdxW-1:0]         rsp_id_o,
    output logic [2*DataW-1:0]      rsp_product_o,
    output logic                    idle_o
`ifdef MULT_RR_SCHED_STATS_EN
    ,
    input  logic                    stats_clr_i,
    output logic [NumReq*16-1:0]    grant_cnt_o,
    output logic [31:0]             busy_cnt_o
`endif
);

    logic [NumReq-1:0] cand;
    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              xfer;

    logic [DataW-1:0]  mul_a_q, mul_a_d;
    logic [DataW-1:0]  mul_b_q, mul_b_d;
    tag_t              issue_tag;
    tag_t              tag_q [Latency+1];
    tag_t              last_tag;
    logic              any_inflight;

    assign cand = sched_en_i ? req_valid_i : '0;

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (cand),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (xfer)
    );

    assign req_ready_o = gnt;

    // Idle cycles drive zero operands so the multiplier sees clean bubbles.
    always_comb begin
        mul_a_d         = '0;
        mul_b_d         = '0;
        issue_tag.valid = 1'b0;
        issue_tag.id    = '0;
        if (xfer) begin
            mul_a_d         = req_a_i[gnt_idx*DataW +: DataW];
            mul_b_d         = req_b_i[gnt_idx*DataW +: DataW];
            issue_tag.valid = 1'b1;
            issue_tag.id    = IdW'(gnt_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign mul_a_o = mul_a_q;
    assign mul_b_o = mul_b_q;

    // Tag pipeline mirrors the multiplier depth; stage Latency aligns with the product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k <= Latency; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= issue_tag;
            for (int unsigned k = 1; k <= Latency; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign last_tag = tag_q[Latency];

    always_comb begin
        rsp_valid_o   = '0;
        rsp_id_o      = '0;
        rsp_product_o = '0;
        if (last_tag.valid) begin
            rsp_valid_o   = NumReq'(1) << IdxW'(last_tag.id);
            rsp_id_o      = IdxW'(last_tag.id);
            rsp_product_o = mul_product_i;
        end
    end

    always_comb begin
        any_inflight = 1'b0;
        for (int unsigned k = 0; k <= Latency; k++) begin
            any_inflight = any_inflight | tag_q[k].valid;
        end
        idle_o = !any_inflight && !xfer;
    end

`ifdef MULT_RR_SCHED_STATS_EN
    logic [NumReq*16-1:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]          busy_cnt_q, busy_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        if (stats_clr_i) begin
            grant_cnt_d = '0;
            busy_cnt_d  = '0;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (gnt[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
                end
            end
            if (xfer) begin
                busy_cnt_d = busy_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign busy_cnt_o  = busy_cnt_q;
`endif

endmodule

// File: tb/tb_mult_rr_sched.sv
// Directed bench for mult_rr_sched with a behavioural 5-stage multiplier model.
module tb_mult_rr_sched;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned DataW   = 8;
    localparam int unsigned Latency = 5;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    sched_en = 1'b0;
    logic [NumReq-1:0]       req_valid = '0;
    logic [NumReq*DataW-1:0] req_a = '0;
    logic [NumReq*DataW-1:0] req_b = '0;
    logic [NumReq-1:0]       req_ready;
    logic [DataW-1:0]        mul_a;
    logic [DataW-1:0]        mul_b;
    logic [2*DataW-1:0]      mul_product;
    logic [NumReq-1:0]       rsp_valid;
    logic [1:0]              rsp_id;
    logic [2*DataW-1:0]      rsp_product;
    logic                    idle;
`ifdef MULT_RR_SCHED_STATS_EN
    logic                    stats_clr = 1'b0;
    logic [NumReq*16-1:0]    grant_cnt;
    logic [31:0]             busy_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [2*DataW-1:0] mpipe [Latency];
    logic [15:0]        prod_tab [4];
    logic [3:0]         fair_tab [4];

    always #5 clk_i = ~clk_i;

    // Multiplier model: product of the registered operands appears Latency edges later.
    always @(posedge clk_i) begin
        mpipe[0] <= 16'(mul_a) * 16'(mul_b);
        for (int k = 1; k < Latency; k++) begin
            mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_product = mpipe[Latency-1];

    mult_rr_sched #(
        .NumReq  (NumReq),
        .DataW   (DataW),
        .Latency (Latency)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .sched_en_i    (sched_en),
        .req_valid_i   (req_valid),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_ready_o   (req_ready),
        .mul_a_o       (mul_a),
        .mul_b_o       (mul_b),
        .mul_product_i (mul_product),
        .rsp_valid_o   (rsp_valid),
        .rsp_id_o      (rsp_id),
        .rsp_product_o (rsp_product),
        .idle_o        (idle)
`ifdef MULT_RR_SCHED_STATS_EN
        ,
        .stats_clr_i   (stats_clr),
        .grant_cnt_o   (grant_cnt),
        .busy_cnt_o    (busy_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*DataW +: DataW] = a;
        req_b[idx*DataW +: DataW] = b;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        sched_en  = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        prod_tab = '{16'd65025, 16'd0, 16'd256, 16'd9};
        fair_tab = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
        for (int k = 0; k < Latency; k++) mpipe[k] = '0;

        // Reset values while held in reset
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_idle", 32'(idle), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_mul_a", 32'(mul_a), 32'd0);
        check_eq("rst_mul_b", 32'(mul_b), 32'd0);
        check_eq("rst_rsp_product", 32'(rsp_product), 32'd0);
        rst_ni = 1'b1;

        // Single requester 1: 13*7
        set_op(1, 8'd13, 8'd7);
        sched_en  = 1'b1;
        req_valid = 4'b0010;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        check_eq("single_mul_a", 32'(mul_a), 32'd13);
        check_eq("single_mul_b", 32'(mul_b), 32'd7);
        check_eq("single_busy", 32'(idle), 32'd0);
        repeat (4) tick();
        check_eq("single_early", 32'(rsp_valid), 32'd0);
        tick();
        check_eq("single_rsp_valid", 32'(rsp_valid), 32'b0010);
        check_eq("single_rsp_id", 32'(rsp_id), 32'd1);
        check_eq("single_rsp_product", 32'(rsp_product), 32'd91);
        tick();
        check_eq("single_idle", 32'(idle), 32'd1);
        check_eq("single_done", 32'(rsp_valid), 32'd0);

        // All four valid: strict rotation, responses in grant order
        do_reset();
        set_op(0, 8'd255, 8'd255);
        set_op(1, 8'd0, 8'd123);
        set_op(2, 8'd128, 8'd2);
        set_op(3, 8'd3, 8'd3);
        sched_en  = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c < 8) check_eq("rr_ready", 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 6 && c < 14) begin
                check_eq("rr_rsp_valid", 32'(rsp_valid), 32'(1) << ((c - 6) % 4));
                check_eq("rr_rsp_id", 32'(rsp_id), 32'((c - 6) % 4));
                check_eq("rr_rsp_product", 32'(rsp_product), 32'(prod_tab[(c - 6) % 4]));
            end else begin
                check_eq("rr_rsp_none", 32'(rsp_valid), 32'd0);
            end
            tick();
            if (c == 7) req_valid = '0;
        end

        // Fairness: pointer at 1, requesters 0 and 2 alternate starting at 2
        do_reset();
        sched_en  = 1'b1;
        req_valid = 4'b0001;
        #1;
        check_eq("fair_setup", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq("fair_ready", 32'(req_ready), 32'(fair_tab[j]));
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
        check_eq("fair_drained", 32'(idle), 32'd1);

        // sched_en toggles 1,0,1 with requester 3 always valid
        do_reset();
        set_op(3, 8'd6, 8'd7);
        req_valid = 4'b1000;
        sched_en  = 1'b1;
        #1;
        check_eq("en_ready0", 32'(req_ready), 32'b1000);
        tick();
        set_op(3, 8'd10, 8'd7);
        sched_en = 1'b0;
        #1;
        check_eq("en_ready_off", 32'(req_ready), 32'd0);
        tick();
        check_eq("en_bubble_a", 32'(mul_a), 32'd0);
        sched_en = 1'b1;
        #1;
        check_eq("en_ready2", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        check_eq("en_mul_a2", 32'(mul_a), 32'd10);
        for (int d = 0; d < 6; d++) begin
            #1;
            if (d == 3) begin
                check_eq("en_rsp0_valid", 32'(rsp_valid), 32'b1000);
                check_eq("en_rsp0_product", 32'(rsp_product), 32'd42);
            end else if (d == 5) begin
                check_eq("en_rsp2_valid", 32'(rsp_valid), 32'b1000);
                check_eq("en_rsp2_product", 32'(rsp_product), 32'd70);
            end else begin
                check_eq("en_rsp_gap", 32'(rsp_valid), 32'd0);
            end
            tick();
        end

        // Reset two cycles after an issue drops the in-flight response
        do_reset();
        set_op(0, 8'd5, 8'd5);
        sched_en  = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (2) tick();
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_idle", 32'(idle), 32'd1);
        tick();
        rst_ni = 1'b1;
        for (int d = 0; d < 6; d++) begin
            #1;
            check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        req_valid = 4'b0011;
        #1;
        check_eq("midrst_ptr", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
